// File: rtl/rvh_pmp_check_arb.sv
// Three-client request arbiter and single-cycle PMP check stage with held responses.
// Define RVH_PMP_CHECK_ARB_RR_EN for round-robin arbitration; otherwise fixed priority PTW > DTLB > ITLB.
module rvh_pmp_check_arb #(
   parameter int unsigned PADDR_WIDTH = 56,
   parameter int unsigned TAG_WIDTH   = 4,
   parameter int unsigned REQ_COUNT   = 3
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [REQ_COUNT-1:0]             req_vld_i,
   output logic [REQ_COUNT-1:0]             req_rdy_o,
   input  logic [REQ_COUNT*PADDR_WIDTH-1:0] req_paddr_i,
   input  logic [REQ_COUNT*2-1:0]           req_access_type_i,
   input  logic [REQ_COUNT*2-1:0]           req_priv_lvl_i,
   input  logic [REQ_COUNT*TAG_WIDTH-1:0]   req_tag_i,
   output logic [REQ_COUNT-1:0]             resp_vld_o,
   input  logic [REQ_COUNT-1:0]             resp_rdy_i,
   output logic                             resp_fail_o,
   output logic [TAG_WIDTH-1:0]             resp_tag_o,
   input  logic                             pmp_cfg_set_vld_i,
   output logic                             permission_check_vld_o,
   output logic [PADDR_WIDTH-1:0]           permission_check_paddr_o,
   output logic [1:0]                       permission_check_access_type_o,
   output logic [1:0]                       priv_lvl_o,
   input  logic                             permission_check_fail_i
);

   localparam int unsigned IW = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;

   typedef enum logic [1:0] {IDLE, CHECK, RESP} state_e;

   state_e                 state_q;
   logic [1:0]             blk_q;
   logic [REQ_COUNT-1:0]   owner_q;
   logic [PADDR_WIDTH-1:0] paddr_q;
   logic [1:0]             type_q;
   logic [1:0]             priv_q;
   logic [TAG_WIDTH-1:0]   tag_q;
   logic                   fail_q;

   logic                   stalled;
   logic                   resp_hsk;
   logic                   accept_ok;
   logic                   accept;
   logic [REQ_COUNT-1:0]   grant;
   logic [IW-1:0]          gidx;
   logic                   found;

`ifdef RVH_PMP_CHECK_ARB_RR_EN
   logic [IW-1:0] ptr_q;
   int unsigned   k;

   // Search starts at ptr_q and wraps, so the client after the last grant wins ties.
   always_comb begin
      grant = '0;
      gidx  = '0;
      found = 1'b0;
      k     = 0;
      for (int unsigned i = 0; i < REQ_COUNT; i++) begin
         k = 32'(ptr_q) + i;
         if (k >= REQ_COUNT) k = k - REQ_COUNT;
         if (!found && req_vld_i[IW'(k)]) begin
            found = 1'b1;
            gidx  = IW'(k);
         end
      end
      if (found) grant[gidx] = 1'b1;
   end
`else
   always_comb begin
      grant = '0;
      gidx  = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < REQ_COUNT; i++) begin
         if (!found && req_vld_i[IW'(i)]) begin
            found = 1'b1;
            gidx  = IW'(i);
         end
      end
      if (found) grant[gidx] = 1'b1;
   end
`endif

   assign stalled   = (blk_q != 2'd0);
   assign resp_hsk  = (state_q == RESP) && (|(resp_rdy_i & owner_q));
   assign accept_ok = ((state_q == IDLE) || resp_hsk) && !stalled && !pmp_cfg_set_vld_i;
   assign accept    = accept_ok && found;

   assign req_rdy_o                      = accept_ok ? grant : '0;
   assign resp_vld_o                     = (state_q == RESP) ? owner_q : '0;
   assign resp_fail_o                    = fail_q;
   assign resp_tag_o                     = tag_q;
   assign permission_check_vld_o         = (state_q == CHECK);
   assign permission_check_paddr_o       = paddr_q;
   assign permission_check_access_type_o = type_q;
   assign priv_lvl_o                     = priv_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         blk_q   <= 2'd0;
         owner_q <= '0;
         paddr_q <= '0;
         type_q  <= 2'd0;
         priv_q  <= 2'd0;
         tag_q   <= '0;
         fail_q  <= 1'b0;
`ifdef RVH_PMP_CHECK_ARB_RR_EN
         ptr_q   <= '0;
`endif
      end else begin
         // Stall window covers the write cycle plus two more before the next accept.
         if (pmp_cfg_set_vld_i) blk_q <= 2'd2;
         else if (stalled)      blk_q <= blk_q - 2'd1;

         if (accept) begin
            owner_q <= grant;
            paddr_q <= req_paddr_i[gidx*PADDR_WIDTH +: PADDR_WIDTH];
            type_q  <= req_access_type_i[gidx*2 +: 2];
            priv_q  <= req_priv_lvl_i[gidx*2 +: 2];
            tag_q   <= req_tag_i[gidx*TAG_WIDTH +: TAG_WIDTH];
`ifdef RVH_PMP_CHECK_ARB_RR_EN
            ptr_q   <= (gidx == IW'(REQ_COUNT - 1)) ? '0 : gidx + 1'b1;
`endif
         end

         unique case (state_q)
            IDLE:    if (accept) state_q <= CHECK;
            CHECK: begin
               fail_q  <= permission_check_fail_i;
               state_q <= RESP;
            end
            RESP:    if (resp_hsk) state_q <= accept ? CHECK : IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rvh_pmp_check_arb.sv
// Cycle-table bench for rvh_pmp_check_arb with a response scoreboard and a small PMP model.
module tb_rvh_pmp_check_arb;

   localparam int PW = 56;
   localparam int TW = 4;
   localparam int RC = 3;

`ifdef RVH_PMP_CHECK_ARB_RR_EN
   localparam logic [2:0] G2 = 3'b010;
   localparam logic [2:0] G3 = 3'b100;
`else
   localparam logic [2:0] G2 = 3'b001;
   localparam logic [2:0] G3 = 3'b001;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [RC-1:0]     req_vld_i;
   logic [RC-1:0]     req_rdy_o;
   logic [RC*PW-1:0]  req_paddr_i;
   logic [RC*2-1:0]   req_access_type_i;
   logic [RC*2-1:0]   req_priv_lvl_i;
   logic [RC*TW-1:0]  req_tag_i;
   logic [RC-1:0]     resp_vld_o;
   logic [RC-1:0]     resp_rdy_i;
   logic              resp_fail_o;
   logic [TW-1:0]     resp_tag_o;
   logic              pmp_cfg_set_vld_i;
   logic              permission_check_vld_o;
   logic [PW-1:0]     permission_check_paddr_o;
   logic [1:0]        permission_check_access_type_o;
   logic [1:0]        priv_lvl_o;
   logic              permission_check_fail_i;

   // PMP model: addresses with bit 12 set are denied.
   assign permission_check_fail_i = permission_check_paddr_o[12];

   rvh_pmp_check_arb #(
      .PADDR_WIDTH (PW),
      .TAG_WIDTH   (TW),
      .REQ_COUNT   (RC)
   ) dut (
      .clk                            (clk),
      .rst                            (rst),
      .req_vld_i                      (req_vld_i),
      .req_rdy_o                      (req_rdy_o),
      .req_paddr_i                    (req_paddr_i),
      .req_access_type_i              (req_access_type_i),
      .req_priv_lvl_i                 (req_priv_lvl_i),
      .req_tag_i                      (req_tag_i),
      .resp_vld_o                     (resp_vld_o),
      .resp_rdy_i                     (resp_rdy_i),
      .resp_fail_o                    (resp_fail_o),
      .resp_tag_o                     (resp_tag_o),
      .pmp_cfg_set_vld_i              (pmp_cfg_set_vld_i),
      .permission_check_vld_o         (permission_check_vld_o),
      .permission_check_paddr_o       (permission_check_paddr_o),
      .permission_check_access_type_o (permission_check_access_type_o),
      .priv_lvl_o                     (priv_lvl_o),
      .permission_check_fail_i        (permission_check_fail_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] vld;
      logic [2:0] rrdy;
      logic       cfg;
      logic       fset;
      logic [2:0] erdy;
      logic [2:0] eresp;
      logic       epcv;
   } vec_t;

   typedef struct {
      logic [2:0]  owner;
      logic [55:0] paddr;
      logic [1:0]  atype;
      logic [1:0]  priv;
      logic [3:0]  tag;
      logic        fail;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic logic [55:0] paddr_f(input int idx, input logic fset);
      return 56'h8000_0000 + (56'(idx) << 20) + (56'(fset) << 12);
   endfunction

   function automatic logic [3:0] tag_f(input int idx, input int c);
      return 4'(idx * 3 + c);
   endfunction

   function automatic logic [1:0] priv_f(input int idx, input int c);
      return 2'(idx + c);
   endfunction

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [2:0] vld, input logic [2:0] rrdy, input logic cfg,
                      input logic fset, input logic [2:0] erdy, input logic [2:0] eresp,
                      input logic epcv);
      vec_t v;
      v.vld = vld; v.rrdy = rrdy; v.cfg = cfg; v.fset = fset;
      v.erdy = erdy; v.eresp = eresp; v.epcv = epcv;
      tbl.push_back(v);
   endtask

   // One clock cycle: drive at posedge+1, check at posedge+3, then advance.
   task automatic step(input logic [2:0] vld, input logic [2:0] rrdy, input logic cfg,
                       input logic rstv, input logic fset, input logic [2:0] erdy,
                       input logic [2:0] eresp, input logic epcv, input int idx);
      exp_t e;
      rst               = rstv;
      req_vld_i         = vld;
      resp_rdy_i        = rrdy;
      pmp_cfg_set_vld_i = cfg;
      for (int c = 0; c < RC; c++) begin
         req_paddr_i[c*PW +: PW]      = paddr_f(idx, fset);
         req_access_type_i[c*2 +: 2]  = 2'(c);
         req_priv_lvl_i[c*2 +: 2]     = priv_f(idx, c);
         req_tag_i[c*TW +: TW]        = tag_f(idx, c);
      end
      #2;
      cmp($sformatf("c%0d_req_rdy", idx), 64'(req_rdy_o), 64'(erdy));
      cmp($sformatf("c%0d_resp_vld", idx), 64'(resp_vld_o), 64'(eresp));
      cmp($sformatf("c%0d_chk_vld", idx), 64'(permission_check_vld_o), 64'(epcv));
      if (epcv || eresp != 3'b000) begin
         if (sb.size() == 0) begin
            cmp($sformatf("c%0d_sb_nonempty", idx), 64'(sb.size()), 64'd1);
         end else begin
            e = sb[0];
            if (epcv) begin
               cmp($sformatf("c%0d_chk_paddr", idx), 64'(permission_check_paddr_o), 64'(e.paddr));
               cmp($sformatf("c%0d_chk_type", idx), 64'(permission_check_access_type_o), 64'(e.atype));
               cmp($sformatf("c%0d_chk_priv", idx), 64'(priv_lvl_o), 64'(e.priv));
            end else begin
               cmp($sformatf("c%0d_resp_owner", idx), 64'(eresp), 64'(e.owner));
               cmp($sformatf("c%0d_resp_fail", idx), 64'(resp_fail_o), 64'(e.fail));
               cmp($sformatf("c%0d_resp_tag", idx), 64'(resp_tag_o), 64'(e.tag));
               if ((eresp & rrdy) != 3'b000) void'(sb.pop_front());
            end
         end
      end
      for (int c = 0; c < RC; c++) begin
         if (erdy[c]) begin
            e.owner = 3'b001 << c;
            e.paddr = paddr_f(idx, fset);
            e.atype = 2'(c);
            e.priv  = priv_f(idx, c);
            e.tag   = tag_f(idx, c);
            e.fail  = fset;
            sb.push_back(e);
         end
      end
      if (rstv) sb.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tagn);
      rst               = 1'b0;
      req_vld_i         = '0;
      resp_rdy_i        = '0;
      pmp_cfg_set_vld_i = 1'b0;
      #2;
      cmp({tagn, "_req_rdy"}, 64'(req_rdy_o), 64'd0);
      cmp({tagn, "_resp_vld"}, 64'(resp_vld_o), 64'd0);
      cmp({tagn, "_chk_vld"}, 64'(permission_check_vld_o), 64'd0);
      cmp({tagn, "_resp_fail"}, 64'(resp_fail_o), 64'd0);
      cmp({tagn, "_resp_tag"}, 64'(resp_tag_o), 64'd0);
      cmp({tagn, "_chk_paddr"}, 64'(permission_check_paddr_o), 64'd0);
      cmp({tagn, "_chk_type"}, 64'(permission_check_access_type_o), 64'd0);
      cmp({tagn, "_priv"}, 64'(priv_lvl_o), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst               = 1'b1;
      req_vld_i         = '0;
      resp_rdy_i        = '0;
      pmp_cfg_set_vld_i = 1'b0;
      req_paddr_i       = '0;
      req_access_type_i = '0;
      req_priv_lvl_i    = '0;
      req_tag_i         = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("reset");

      //   vld     rrdy    cfg   fset  erdy    eresp   pcv
      // single DTLB read, fail=0
      add(3'b010, 3'b000, 1'b0, 1'b0, 3'b010, 3'b000, 1'b0);
      add(3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1);
      add(3'b000, 3'b010, 1'b0, 1'b0, 3'b000, 3'b010, 1'b0);
      add(3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
      // ITLB, fail=1, response held for 5 cycles while others request
      add(3'b100, 3'b000, 1'b0, 1'b1, 3'b100, 3'b000, 1'b0);
      add(3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1);
      for (int i = 0; i < 5; i++) add(3'b011, 3'b011, 1'b0, 1'b0, 3'b000, 3'b100, 1'b0);
      add(3'b000, 3'b100, 1'b0, 1'b0, 3'b000, 3'b100, 1'b0);
      add(3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
      // all three valid continuously
      add(3'b111, 3'b111, 1'b0, 1'b0, 3'b001, 3'b000, 1'b0);
      add(3'b111, 3'b111, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1);
      add(3'b111, 3'b111, 1'b0, 1'b1, G2,     3'b001, 1'b0);
      add(3'b111, 3'b111, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1);
      add(3'b111, 3'b111, 1'b0, 1'b0, G3,     G2,     1'b0);
      add(3'b111, 3'b111, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1);
      add(3'b111, 3'b111, 1'b0, 1'b0, 3'b001, G3,     1'b0);
      add(3'b111, 3'b111, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1);
      add(3'b000, 3'b111, 1'b0, 1'b0, 3'b000, 3'b001, 1'b0);
      add(3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
      // cfg write with PTW waiting: stalled W..W+2, accept W+3
      add(3'b001, 3'b000, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0);
      add(3'b001, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
      add(3'b001, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
      add(3'b001, 3'b000, 1'b0, 1'b0, 3'b001, 3'b000, 1'b0);
      // cfg write during CHECK does not abort, but blocks the re-accept at handshake
      add(3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 3'b000, 1'b1);
      add(3'b001, 3'b001, 1'b0, 1'b0, 3'b000, 3'b001, 1'b0);
      add(3'b001, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
      add(3'b001, 3'b000, 1'b0, 1'b0, 3'b001, 3'b000, 1'b0);
      add(3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1);
      // back-to-back accept in RESP, new request fails
      add(3'b010, 3'b001, 1'b0, 1'b1, 3'b010, 3'b001, 1'b0);
      add(3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1);
      add(3'b000, 3'b010, 1'b0, 1'b0, 3'b000, 3'b010, 1'b0);
      add(3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].vld, tbl[i].rrdy, tbl[i].cfg, 1'b0, tbl[i].fset,
              tbl[i].erdy, tbl[i].eresp, tbl[i].epcv, i);
      end
      cmp("table_sb_drained", 64'(sb.size()), 64'd0);

      // reset during CHECK: request dropped, pointer and latches cleared
      step(3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 3'b010, 3'b000, 1'b0, 40);
      step(3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 1'b1, 41);
      check_reset_vals("midrst");
      for (int i = 0; i < 4; i++) begin
         step(3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 42 + i);
      end
      step(3'b111, 3'b000, 1'b0, 1'b0, 1'b1, 3'b001, 3'b000, 1'b0, 46);
      step(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 47);
      step(3'b000, 3'b001, 1'b0, 1'b0, 1'b0, 3'b000, 3'b001, 1'b0, 48);
      step(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 49);
      cmp("final_sb_drained", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
